// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity encodings, serializer/deserializer state
// encodings, line-level constants and small parity helpers.
package usrt_pkg;

  // Parity mode encodings (3 is reserved and behaves like PAR_NONE)
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Frame state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Line levels: the line idles low, start is high, stop is low
  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  // True when the mode inserts a parity bit into the frame
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity bit from the XOR-reduction of the data bits
  function automatic logic par_bit(input logic [1:0] mode, input logic data_xor);
    return data_xor ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/usrt_bit_timer.sv
// Bit-period timer: counts 0..DIV-1, restarts on clr_i, and flags the last
// cycle of each bit period with tick_o. Shared by the transmit and receive paths.
module usrt_bit_timer #(
  parameter int DIV = 80,
  localparam int CNT_W = $clog2(DIV)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_o  = cnt_q;

  // Next count: wrap at the bit boundary, restart on a state entry
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usrt_serializer_p.sv
// Parametrised USRT transmit serializer. Frames each accepted word as
// start | DATA_W data bits (LSB first) | optional parity | 1 or 2 stop bits,
// each bit held for DIV clock cycles.
// Optional build macro USRT_CLK_OUT_EN adds the uClk output, a registered
// bit clock that rises mid-bit so a receiver can sample on its rising edge.
module usrt_serializer_p
  import usrt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = 80
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        par_mode,
  input  logic              stop_two,
  output logic              Rx,
  output logic              busy,
  output logic              frame_done
`ifdef USRT_CLK_OUT_EN
  ,
  output logic              uClk
`endif
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop_two_q, stop_two_d;
  logic              rx_q, rx_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic              bit_tick;
  logic              timer_clr;
  logic              last_stop;
  logic              accept;

  // The counter restarts on every state change and is held at zero while idle
  assign timer_clr = (state_d != state_q) || (state_q == ST_IDLE);

  usrt_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk_i  (pClk),
    .rst_ni (pReset),
    .clr_i  (timer_clr),
    .cnt_o  (bit_cnt),
    .tick_o (bit_tick)
  );

  assign last_stop  = (stop_idx_q == stop_two_q);
  assign tx_ready   = (state_q == ST_IDLE) ||
                      ((state_q == ST_STOP) && last_stop && bit_tick);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != ST_IDLE);
  assign Rx         = rx_q;
  assign frame_done = done_q;

  // Frame sequencing; Rx is computed for the state being entered so the
  // registered line output lines up with the state register
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop_two_d = stop_two_q;
    rx_d       = rx_q;
    done_d     = 1'b0;

    case (state_q)
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          rx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              rx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              rx_d       = STOP_BIT;
              stop_idx_d = 1'b0;
            end
          end else begin
            rx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          rx_d       = STOP_BIT;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (last_stop) begin
            state_d = ST_IDLE;
            rx_d    = LINE_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // An accept overrides the idle return so back-to-back frames have no gap;
    // frame_done for the finishing frame is still raised above
    if (accept) begin
      state_d    = ST_START;
      rx_d       = START_BIT;
      shift_d    = tx_data;
      par_en_d   = par_enabled(par_mode);
      par_bit_d  = par_bit(par_mode, ^tx_data);
      stop_two_d = stop_two;
    end
  end

  // Frame state registers
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_two_q <= 1'b0;
      rx_q       <= LINE_IDLE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop_two_q <= stop_two_d;
      rx_q       <= rx_d;
      done_q     <= done_d;
    end
  end

`ifdef USRT_CLK_OUT_EN
  logic             uclk_q, uclk_d;
  logic [CNT_W-1:0] cnt_next;

  // Predict the counter value after this edge so uClk is aligned with Rx
  assign cnt_next = (timer_clr || bit_tick) ? '0 : (bit_cnt + 1'b1);
  assign uclk_d   = (state_d != ST_IDLE) && (cnt_next >= CNT_W'(DIV / 2));
  assign uClk     = uclk_q;

  // Bit clock: low for the first half of each bit, high for the second
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      uclk_q <= 1'b0;
    end else begin
      uclk_q <= uclk_d;
    end
  end
`else
  logic unused_bit_cnt;
  assign unused_bit_cnt = ^bit_cnt;
`endif

endmodule

// File: tb/tb_usrt_serializer_p.sv
// Self-checking bench for usrt_serializer_p (DATA_W=8, DIV=4). A reference
// model expands each accepted word into its per-cycle line waveform and the
// DUT outputs are compared against it every cycle.
module tb_usrt_serializer_p;

  localparam int DATA_W = 8;
  localparam int DIV    = 4;

  logic              pClk = 1'b0;
  logic              pReset = 1'b0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        par_mode;
  logic              stop_two;
  logic              Rx;
  logic              busy;
  logic              frame_done;
`ifdef USRT_CLK_OUT_EN
  logic              uClk;
`endif

  usrt_serializer_p #(
    .DATA_W (DATA_W),
    .DIV    (DIV)
  ) dut (
    .pClk       (pClk),
    .pReset     (pReset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .par_mode   (par_mode),
    .stop_two   (stop_two),
    .Rx         (Rx),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef USRT_CLK_OUT_EN
    ,
    .uClk       (uClk)
`endif
  );

  always #5 pClk = ~pClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected line level and position-in-bit per future cycle
  bit q_rx[$];
  int q_ph[$];
  bit done_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand one word into its frame: start, data LSB first, parity, stops
  function automatic int push_frame(input logic [7:0] d, input logic [1:0] m, input logic s);
    bit bits[$];
    bits.push_back(1'b1);
    for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
    if (m == 2'd1) bits.push_back(^d);
    else if (m == 2'd2) bits.push_back(~(^d));
    bits.push_back(1'b0);
    if (s) bits.push_back(1'b0);
    foreach (bits[b]) begin
      for (int p = 0; p < DIV; p++) begin
        q_rx.push_back(bits[b]);
        q_ph.push_back(p);
      end
    end
    return bits.size() * DIV;
  endfunction

  task automatic check_all();
    bit busy_e;
    bit rx_e;
    busy_e = (q_rx.size() != 0);
    rx_e   = busy_e ? q_rx[0] : 1'b0;
    check_eq("rx", 32'(Rx), 32'(rx_e));
    check_eq("busy", 32'(busy), 32'(busy_e));
    check_eq("tx_ready", 32'(tx_ready), 32'(q_rx.size() <= 1));
    check_eq("frame_done", 32'(frame_done), 32'(done_exp));
`ifdef USRT_CLK_OUT_EN
    check_eq("uClk", 32'(uClk), 32'(busy_e && (q_ph[0] >= DIV / 2)));
`endif
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model
  task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] m,
                      input logic s, output bit acc, output int flen);
    bit rdy;
    check_all();
    rdy      = (q_rx.size() <= 1);
    tx_valid = v;
    tx_data  = d;
    par_mode = m;
    stop_two = s;
    acc      = v && rdy;
    flen     = 0;
    done_exp = (q_rx.size() == 1);
    if (q_rx.size() != 0) begin
      void'(q_rx.pop_front());
      void'(q_ph.pop_front());
    end
    if (acc) flen = push_frame(d, m, s);
    @(negedge pClk);
  endtask

  // Hold valid and data until the word is accepted
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s);
    bit acc;
    int flen;
    int waited;
    acc    = 1'b0;
    waited = 0;
    flen   = 0;
    while (!acc && waited < 200) begin
      tick(1'b1, d, m, s, acc, flen);
      waited++;
    end
    $display("frame data=%02h par_mode=%0d stop_two=%0b waited=%0d frame_cycles=%0d",
             d, m, s, waited - 1, flen);
  endtask

  // Idle cycles with valid low; other inputs wander to show they are ignored
  task automatic idle(input int n);
    bit acc;
    int flen;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc, flen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    par_mode = 2'd0;
    stop_two = 1'b0;
    repeat (3) @(negedge pClk);
    #2 pReset = 1'b1;
    @(negedge pClk);

    // Directed frames
    send(8'hA5, 2'd1, 1'b0); idle(46);
    send(8'hA5, 2'd2, 1'b0); idle(46);
    send(8'hA5, 2'd3, 1'b0); idle(42);
    send(8'hFF, 2'd1, 1'b1); idle(50);
    send(8'h01, 2'd1, 1'b0); send(8'h80, 2'd1, 1'b0); idle(46);

    // Reset in the middle of a frame, with valid asserted during reset
    send(8'h5A, 2'd1, 1'b0); idle(9);
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    #1 pReset = 1'b0;
    #1;
    check_eq("rst_rx", 32'(Rx), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_tx_ready", 32'(tx_ready), 32'(1));
    check_eq("rst_frame_done", 32'(frame_done), 32'(0));
`ifdef USRT_CLK_OUT_EN
    check_eq("rst_uClk", 32'(uClk), 32'(0));
`endif
    q_rx.delete();
    q_ph.delete();
    done_exp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pClk);
      check_eq("rst_hold_busy", 32'(busy), 32'(0));
      check_eq("rst_hold_rx", 32'(Rx), 32'(0));
    end
    tx_valid = 1'b0;
    #2 pReset = 1'b1;
    @(negedge pClk);
    $display("reset applied mid-frame and released");
    idle(3);
    send(8'h3C, 2'd0, 1'b1); idle(50);

    // Randomized frames with random gaps, including back-to-back bursts
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic [1:0] m;
      logic       s;
      int         gap;
      d   = 8'($urandom);
      m   = 2'($urandom_range(0, 3));
      s   = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      send(d, m, s);
      idle(gap);
    end
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usrt_serializer_p.md
Name: usrt_serializer_p

Overview:
Parametrised successor to the fixed 8-bit USRT serializer.
- Accepts words over a valid/ready handshake and frames each one as start, DATA_W data bits, optional parity, and 1 or 2 stop bits.
- Shifts the frame out on Rx, holding each bit for DIV pClk cycles from an internal bit-period counter.
- Sits between the AMBA-side data register and the USRT line, replacing the separate baud generator and serializer pair on the transmit path.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..16.
DIV, 80, pClk cycles per bit period; legal range 2..1023.

Ports:
pClk  in  1  system clock; all logic on rising edge.
pReset  in  1  asynchronous, active-low reset.
tx_data  in  DATA_W  word to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a word this cycle.
par_mode  in  2  parity: 0 none, 1 even, 2 odd, 3 reserved (treated as none).
stop_two  in  1  1 = two stop bits, 0 = one stop bit.
Rx  out  1  serial line output.
busy  out  1  a frame is in progress.
frame_done  out  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Line polarity: idle 0, start bit 1, stop bit(s) 0. Data goes LSB first.
- Even parity bit = XOR of the data bits. Odd parity bit = its inverse.
- States: IDLE, START, DATA, PARITY, STOP.
- Bit counter: bit_cnt runs 0..DIV-1 and resets to 0 on every state entry. A bit boundary is bit_cnt==DIV-1.
- Accept: a word is accepted when tx_valid && tx_ready at a rising edge. On that edge:
  - latch tx_data, par_mode and stop_two;
  - go to START and drive Rx=1 (registered, latency 1 cycle);
  - later changes to the inputs do not affect the frame in flight.
- Transitions, each on a bit boundary:
  - START -> DATA.
  - DATA repeats until DATA_W bits are sent, then goes to PARITY if parity is enabled, else to STOP.
  - PARITY -> STOP.
  - STOP lasts 1 or 2 bit periods, then goes to IDLE with Rx=0.
- tx_ready = IDLE, OR (STOP && final stop bit && bit_cnt==DIV-1). This allows back-to-back frames with no idle gap. An accept in that cycle goes directly to START.
- busy = 1 in every state except IDLE.
- frame_done pulses for exactly one cycle after the final stop bit, on the same edge that leaves STOP. This holds even when a new frame is accepted on that edge.
- Frame length is (1 + DATA_W + P + S) * DIV cycles, where P = 1 if parity is enabled and S = 1 + stop_two.
- tx_valid without tx_ready is ignored. The requester must hold tx_valid and tx_data until accepted.
- Reset values: state IDLE, Rx 0, busy 0, frame_done 0, tx_ready 1, bit_cnt 0, shift register 0.
- Reset asserted mid-frame aborts immediately; no partial frame resumes after release.
- tx_valid asserted during reset is not accepted.

Optional Feature:
USRT_CLK_OUT_EN
- Defined: adds output uClk (1 bit, registered). uClk = 0 in IDLE. While busy, uClk = 0 for bit_cnt < DIV/2 and 1 otherwise, so a receiver samples mid-bit on the rising edge. Reset value 0.
- Undefined: the uClk port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package usrt_pkg holds:
  - the parity encodings PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the state encodings;
  - line-level constants LINE_IDLE=0, START_BIT=1, STOP_BIT=0.
- The deserializer successor shares these constants.
- One sub-module: usrt_bit_timer, holding the bit_cnt counter with a clear input and a tick output, parametrised by DIV. The receiver reuses it.

Test Plan:
1. DATA_W=8, DIV=4, par_mode=1, stop_two=0, tx_data=8'hA5 -> Rx in 4-cycle bits: 1 | 1,0,1,0,0,1,0,1 | 0 | 0. frame_done pulses 44 cycles after accept; busy high throughout.
2. Same as 1 with par_mode=2 -> parity bit 1. par_mode=3 -> no parity bit and frame_done at 40 cycles.
3. stop_two=1, tx_data=8'hFF, par_mode=1 -> parity 0, two stop bits, frame_done at 48 cycles. tx_ready is high only in the last cycle of the second stop bit.
4. Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> the second start bit follows the first stop bit with no idle cycle, and frame_done pulses twice, 44 cycles apart.
5. Assert pReset low at cycle 10 of a frame -> Rx=0, busy=0, tx_ready=1 asynchronously. After release, a new word 8'h3C transmits correctly from its start bit.
6. With USRT_CLK_OUT_EN, DIV=4 -> uClk follows the pattern 0,0,1,1 per bit while busy and stays 0 in idle. Changing tx_data mid-frame does not alter the bits on Rx.
